// File: rtl/demux_stream_nch_if.sv
// Purpose: stream bundle between one command source and NUM_CH per-channel consumers.
// Latency: wires only; no storage in the interface.
// Backpressure: in_ready toward the source, out_ready from each consumer.
interface demux_stream_nch_if #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic              in_bcast;
    logic [DATA_W-1:0] in_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [DATA_W-1:0] out_data;
    logic [NUM_CH-1:0] onehot;
    logic              err_sel;
    logic [7:0]        drop_cnt;

    // Source/consumer side of the bundle.
    modport master (
        output in_valid, in_sel, in_bcast, in_data, out_ready,
        input  in_ready, out_valid, out_data, onehot, err_sel, drop_cnt
    );

    // Demultiplexer side of the bundle.
    modport slave (
        input  in_valid, in_sel, in_bcast, in_data, out_ready,
        output in_ready, out_valid, out_data, onehot, err_sel, drop_cnt
    );
endinterface

// File: rtl/demux_stream_nch.sv
// Purpose: registered 1-to-NUM_CH stream demux with broadcast, one-hot record and drop counter.
// Latency: one cycle from input accept to out_valid; out_data is registered.
// Backpressure: in_ready is high only when every pending channel completes this cycle.
module demux_stream_nch #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_stream_nch_if.slave    bus
);
    localparam logic [NUM_CH-1:0] ALL_CH = '1;
    localparam logic [NUM_CH-1:0] CH0    = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] onehot_q, onehot_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [NUM_CH-1:0] remain;
    logic              accept;
    logic              sel_ok;

    // Channels still pending after this edge's handshakes; the input may only
    // be taken when nothing would be left over.
    assign remain       = pend_q & ~bus.out_ready;
    assign bus.in_ready = (remain == '0);
    assign accept       = bus.in_valid & bus.in_ready;
    assign sel_ok       = (int'(bus.in_sel) < NUM_CH);

    assign bus.out_valid = pend_q;
    assign bus.out_data  = data_q;
    assign bus.onehot    = onehot_q;
    assign bus.err_sel   = err_q;
    assign bus.drop_cnt  = drop_cnt_q;

    // Next-state: retire completed channels, then load a new destination set.
    // A dropped select leaves data and onehot untouched and pend empty.
    always_comb begin
        pend_d     = remain;
        onehot_d   = onehot_q;
        data_d     = data_q;
        err_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            if (bus.in_bcast) begin
                pend_d   = ALL_CH;
                onehot_d = ALL_CH;
                data_d   = bus.in_data;
            end else if (sel_ok) begin
                pend_d   = CH0 << bus.in_sel;
                onehot_d = CH0 << bus.in_sel;
                data_d   = bus.in_data;
            end else begin
                pend_d = '0;
                err_d  = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

    // State registers; reset discards any pending transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            onehot_q   <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            pend_q     <= pend_d;
            onehot_q   <= onehot_d;
            data_q     <= data_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_demux_stream_nch.sv
// Purpose: scoreboard bench for demux_stream_nch, 8-channel and 6-channel instances.
// Latency: expects out_valid one cycle after accept.
// Backpressure: exercises per-channel stalls, partial broadcast and back-to-back accept.
module tb_demux_stream_nch;
    logic clk;
    logic rst_n;

    demux_stream_nch_if #(.SEL_W(3), .NUM_CH(8), .DATA_W(8)) a ();
    demux_stream_nch_if #(.SEL_W(3), .NUM_CH(6), .DATA_W(8)) b ();

    demux_stream_nch #(.SEL_W(3), .NUM_CH(8), .DATA_W(8)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    demux_stream_nch #(.SEL_W(3), .NUM_CH(6), .DATA_W(8)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake seen away from the edge must match the next
    // expected delivery for that instance.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 8; i++) begin
                if (a.out_valid[i] && a.out_ready[i]) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected: got ch %0d data 0x%0h, expected no delivery", i, a.out_data);
                    end else begin
                        ea = qa.pop_front();
                        chk("a_ch", i, ea.ch);
                        chk("a_data", {24'd0, a.out_data}, {24'd0, ea.d});
                    end
                end
            end
            for (int i = 0; i < 6; i++) begin
                if (b.out_valid[i] && b.out_ready[i]) begin
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: got ch %0d data 0x%0h, expected no delivery", i, b.out_data);
                    end else begin
                        eb = qb.pop_front();
                        chk("b_ch", i, eb.ch);
                        chk("b_data", {24'd0, b.out_data}, {24'd0, eb.d});
                    end
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        a.in_valid  = 1'b0; a.in_sel = '0; a.in_bcast = 1'b0; a.in_data = '0; a.out_ready = '0;
        b.in_valid  = 1'b0; b.in_sel = '0; b.in_bcast = 1'b0; b.in_data = '0; b.out_ready = '0;

        // Reset values, then unchanged after release.
        step(); step();
        chk("rst_out_valid", {24'd0, a.out_valid}, 32'h00);
        chk("rst_onehot",    {24'd0, a.onehot},    32'h00);
        chk("rst_drop_cnt",  {24'd0, a.drop_cnt},  32'h00);
        chk("rst_in_ready",  {31'd0, a.in_ready},  32'h1);
        chk("rst_err_sel",   {31'd0, a.err_sel},   32'h0);
        rst_n = 1'b1;
        step();
        chk("rel_out_valid", {24'd0, a.out_valid}, 32'h00);
        chk("rel_onehot",    {24'd0, a.onehot},    32'h00);
        chk("rel_in_ready",  {31'd0, a.in_ready},  32'h1);

        // Unicast to channel 5 with all consumers ready.
        a.out_ready = 8'hFF;
        a.in_valid = 1'b1; a.in_sel = 3'd5; a.in_data = 8'hA5;
        qa.push_back('{5, 8'hA5});
        step();
        a.in_valid = 1'b0;
        chk("uni_out_valid", {24'd0, a.out_valid}, 32'h20);
        chk("uni_out_data",  {24'd0, a.out_data},  32'hA5);
        chk("uni_onehot",    {24'd0, a.onehot},    32'h20);
        step();
        chk("uni_done",      {24'd0, a.out_valid}, 32'h00);
        chk("uni_onehot_hold", {24'd0, a.onehot},  32'h20);

        // Backpressure on channel 2, then back-to-back accept of channel 6.
        a.out_ready = 8'h00;
        a.in_valid = 1'b1; a.in_sel = 3'd2; a.in_data = 8'h3C;
        qa.push_back('{2, 8'h3C});
        step();
        a.in_sel = 3'd6; a.in_data = 8'h77;
        for (int k = 0; k < 4; k++) begin
            chk("bp_out_valid", {24'd0, a.out_valid}, 32'h04);
            chk("bp_out_data",  {24'd0, a.out_data},  32'h3C);
            chk("bp_in_ready",  {31'd0, a.in_ready},  32'h0);
            step();
        end
        a.out_ready = 8'h04;
        #1;
        chk("bp_release_in_ready", {31'd0, a.in_ready}, 32'h1);
        qa.push_back('{6, 8'h77});
        step();
        a.in_valid = 1'b0;
        a.out_ready = 8'hFF;
        chk("b2b_out_valid", {24'd0, a.out_valid}, 32'h40);
        chk("b2b_out_data",  {24'd0, a.out_data},  32'h77);
        chk("b2b_onehot",    {24'd0, a.onehot},    32'h40);
        step();
        chk("b2b_done",      {24'd0, a.out_valid}, 32'h00);

        // Broadcast with low half ready first, then high half.
        a.out_ready = 8'h0F;
        a.in_valid = 1'b1; a.in_bcast = 1'b1; a.in_sel = 3'd3; a.in_data = 8'h5A;
        for (int c = 0; c < 8; c++) qa.push_back('{c, 8'h5A});
        step();
        a.in_valid = 1'b0; a.in_bcast = 1'b0;
        chk("bc_out_valid_all", {24'd0, a.out_valid}, 32'hFF);
        chk("bc_onehot",        {24'd0, a.onehot},    32'hFF);
        chk("bc_in_ready_0",    {31'd0, a.in_ready},  32'h0);
        step();
        chk("bc_out_valid_hi",  {24'd0, a.out_valid}, 32'hF0);
        chk("bc_in_ready_1",    {31'd0, a.in_ready},  32'h0);
        chk("bc_data_hold",     {24'd0, a.out_data},  32'h5A);
        a.out_ready = 8'hF0;
        #1;
        chk("bc_in_ready_last", {31'd0, a.in_ready},  32'h1);
        step();
        chk("bc_done",          {24'd0, a.out_valid}, 32'h00);

        // Reset asserted between edges while channel 1 is pending.
        a.out_ready = 8'h00;
        a.in_valid = 1'b1; a.in_sel = 3'd1; a.in_data = 8'h11;
        step();
        a.in_valid = 1'b0;
        chk("mid_pending", {24'd0, a.out_valid}, 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {24'd0, a.out_valid}, 32'h00);
        chk("mid_rst_onehot",    {24'd0, a.onehot},    32'h00);
        chk("mid_rst_in_ready",  {31'd0, a.in_ready},  32'h1);
        step();
        rst_n = 1'b1;
        step();

        // Six-channel instance: valid unicast, then a drop that overlaps its completion.
        b.out_ready = 6'h3F;
        b.in_valid = 1'b1; b.in_sel = 3'd5; b.in_data = 8'hC3;
        qb.push_back('{5, 8'hC3});
        step();
        b.in_sel = 3'd7; b.in_data = 8'hEE;
        chk("b_uni_out_valid", {26'd0, b.out_valid}, 32'h20);
        chk("b_uni_in_ready",  {31'd0, b.in_ready},  32'h1);
        step();
        b.in_valid = 1'b0;
        chk("b_drop_out_valid", {26'd0, b.out_valid}, 32'h00);
        chk("b_drop_err",       {31'd0, b.err_sel},   32'h1);
        chk("b_drop_cnt1",      {24'd0, b.drop_cnt},  32'h01);
        chk("b_drop_onehot",    {26'd0, b.onehot},    32'h20);
        chk("b_drop_data",      {24'd0, b.out_data},  32'hC3);
        step();
        chk("b_err_pulse_end",  {31'd0, b.err_sel},   32'h0);
        chk("b_cnt_hold",       {24'd0, b.drop_cnt},  32'h01);

        // Broadcast ignores an out-of-range select.
        b.in_valid = 1'b1; b.in_bcast = 1'b1; b.in_sel = 3'd7; b.in_data = 8'h99;
        for (int c = 0; c < 6; c++) qb.push_back('{c, 8'h99});
        step();
        b.in_valid = 1'b0; b.in_bcast = 1'b0;
        chk("b_bc_out_valid", {26'd0, b.out_valid}, 32'h3F);
        chk("b_bc_err",       {31'd0, b.err_sel},   32'h0);
        step();

        // Select equal to NUM_CH is the first illegal value; run to saturation.
        b.in_valid = 1'b1; b.in_sel = 3'd6; b.in_data = 8'h42;
        for (int k = 0; k < 253; k++) step();
        chk("b_cnt_254", {24'd0, b.drop_cnt}, 32'hFE);
        step();
        chk("b_cnt_255", {24'd0, b.drop_cnt}, 32'hFF);
        b.in_sel = 3'd7;
        for (int k = 0; k < 46; k++) step();
        b.in_valid = 1'b0;
        chk("b_cnt_sat", {24'd0, b.drop_cnt}, 32'hFF);
        chk("b_sat_onehot", {26'd0, b.onehot}, 32'h3F);
        chk("b_sat_out_valid", {26'd0, b.out_valid}, 32'h00);
        step();
        step();

        chk("a_queue_empty", qa.size(), 32'd0);
        chk("b_queue_empty", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_stream_nch.md
Name: demux_stream_nch

Overview:
Parametrised registered demultiplexer, the successor to the fixed 3-to-8 combinational decoder. It routes one DATA_W payload from a single valid/ready input stream to one of NUM_CH output channels chosen by a binary select, or to all channels in broadcast mode. Each channel has its own ready, and a registered one-hot decode of the last accepted select is kept. The block sits between a command source and per-channel consumers, e.g. peripheral or register-bank fan-out.

Parameters:
SEL_W, 3, select width in bits
NUM_CH, 8, number of output channels; legal range 2..2^SEL_W; need not be a power of two
DATA_W, 8, payload width in bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept a transaction this cycle
in_sel  input  SEL_W  destination channel index
in_bcast  input  1  1 = deliver to all channels; in_sel ignored
in_data  input  DATA_W  payload
out_valid  output  NUM_CH  per-channel valid
out_ready  input  NUM_CH  per-channel ready
out_data  output  DATA_W  shared registered payload bus
onehot  output  NUM_CH  registered decode of the last accepted destination
err_sel  output  1  one-cycle pulse when an out-of-range select is dropped
drop_cnt  output  8  count of dropped transactions, saturates at 255

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n. While rst_n=0, all outputs are 0 except in_ready, which is 1.
- Internal state is a pending mask P[NUM_CH-1:0]. The block is IDLE when P=0 and HOLD otherwise. out_valid = P.
- Handshakes:
  - Channel i completes a handshake when out_valid[i] and out_ready[i] are both 1 at a clock edge; bit P[i] clears at that edge.
  - in_ready is combinational: in_ready = (P & ~out_ready) == 0. The block accepts when it is idle, or when every still-pending channel is completing in this cycle. This gives back-to-back throughput of 1 per cycle.
  - A transfer occurs when in_valid and in_ready are both 1 at an edge.
- On an accepted transfer:
  - Broadcast (in_bcast=1): P <= all ones; out_data <= in_data; onehot <= all ones.
  - Unicast with in_sel < NUM_CH: P <= 1<<in_sel; out_data <= in_data; onehot <= 1<<in_sel.
  - Unicast with in_sel >= NUM_CH: the transaction is dropped. P is taken as 0 after the same edge's completions, so P becomes 0. err_sel=1 for exactly the next cycle. drop_cnt increments, holding at 255. out_data and onehot are unchanged.
- Latency: accept at edge k; out_valid is visible in the cycle after edge k. There is no combinational path from in_data to out_data.
- Stability:
  - out_data is held constant while any out_valid bit is set.
  - onehot holds until the next non-dropped accept.
  - An out_valid bit, once set, stays high until its handshake completes; there is no timeout.
- Broadcast completes when every channel has handshaken. Channels may accept on different cycles, and each one clears independently.
- out_ready bits for channels whose out_valid is low are ignored.
- The input is not buffered. While in_ready=0, the source must hold in_valid and its payload stable.
- Reset mid-HOLD: the pending transaction is discarded, and out_valid, onehot and drop_cnt all become 0 immediately.
- err_sel is otherwise 0. drop_cnt is not cleared except by reset.

Test Plan:
- Reset with defaults -> out_valid=0x00, onehot=0x00, drop_cnt=0, in_ready=1; release rst_n -> values unchanged.
- Unicast: sel=5, data=0xA5, out_ready=0xFF -> next cycle out_valid=0x20, out_data=0xA5, onehot=0x20; the following cycle out_valid=0x00.
- Backpressure: sel=2, data=0x3C, out_ready=0x00 for 4 cycles -> out_valid=0x04 and out_data=0x3C steady, in_ready=0; raise out_ready[2] -> in_ready=1 in that cycle and a new sel=6 transfer is accepted back-to-back.
- Broadcast, partial readiness:
  - data=0x5A with out_ready=0x0F -> out_valid goes 0xFF, then 0xF0.
  - Then out_ready=0xF0 -> out_valid=0x00.
  - in_ready stays low until the final completing cycle.
- Out-of-range with NUM_CH=6, SEL_W=3: sel=7, unicast -> no out_valid, err_sel=1 for one cycle, drop_cnt=1; 300 such drops -> drop_cnt=255.
- Reset mid-HOLD: sel=1 pending with out_ready=0; assert rst_n=0 between edges -> out_valid=0x00 and onehot=0x00 immediately, without waiting for a clock edge.
